// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shifter with a one-word holding buffer.
// Words enter over a valid/ready handshake and leave one bit per accepted
// serial transfer. The holding buffer lets the next word wait while the
// current one shifts out, so consecutive words stream without a gap.
module piso_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [DATA_WIDTH-1:0] hold_q,  hold_d;
  logic                  hold_valid_q, hold_valid_d;

  logic                  in_xfer;
  logic                  out_xfer;
  logic                  reload;
  logic [DATA_WIDTH-1:0] shift_next;

  // Output-side view of the shifter; dout is forced low when no bit is valid.
  always_comb begin
    dout_valid = (state_q == SHIFT);
    dout_last  = dout_valid && (cnt_q == CNT_LAST);
    din_ready  = !hold_valid_q;
    dout       = 1'b0;
    if (dout_valid) begin
      dout = MSB_FIRST ? shift_q[DATA_WIDTH-1] : shift_q[0];
    end
  end

  // Handshakes and the shifter moved one place toward its output end.
  always_comb begin
    in_xfer    = din_valid && din_ready;
    out_xfer   = dout_valid && dout_ready;
    // A reload happens whenever the shifter is empty or about to empty.
    reload     = (state_q == IDLE) || (out_xfer && dout_last);
    shift_next = MSB_FIRST ? {shift_q[DATA_WIDTH-2:0], 1'b0}
                           : {1'b0, shift_q[DATA_WIDTH-1:1]};
  end

  // Next-state: reload from hold (priority) or din, else shift or stall.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;

    if (reload) begin
      cnt_d = '0;
      if (hold_valid_q) begin
        // din_ready is low here, so no new word can arrive this cycle.
        shift_d      = hold_q;
        hold_valid_d = 1'b0;
        state_d      = SHIFT;
      end else if (in_xfer) begin
        // Empty hold: a word arriving with the last bit goes straight in.
        shift_d = din;
        state_d = SHIFT;
      end else begin
        shift_d = '0;
        state_d = IDLE;
      end
    end else begin
      if (out_xfer) begin
        shift_d = shift_next;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      // Shifter busy with bits still to go: park the new word.
      if (in_xfer) begin
        hold_d       = din;
        hold_valid_d = 1'b1;
      end
    end
  end

  // State registers; reset discards both the in-flight and the held word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

endmodule
